// File: rtl/write_buffer_pkg.sv
// write_buffer_pkg
// Shared types and helpers for the write buffer slice.
//   wb_entry_t     : one buffered store (word-aligned addr, lane-positioned data, byte enables)
//   drain_state_t  : drain FSM states (IDLE, REQ)
//   encode_be()    : byte-enable pattern for a store
//   encode_entry() : full entry encoding applied at push time
package write_buffer_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wb_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } drain_state_t;

  // Word stores cover all four lanes; byte stores select the lane named by
  // the low address bits.
  function automatic logic [3:0] encode_be(input logic sb, input logic [1:0] lane);
    logic [3:0] be;
    if (sb) begin
      be = 4'b0001 << lane;
    end else begin
      be = 4'b1111;
    end
    return be;
  endfunction

  // Byte data is replicated on every lane so memory can take whichever lane
  // the byte enables select without a shifter on the drain path.
  function automatic wb_entry_t encode_entry(input logic        sb,
                                             input logic [31:0] addr,
                                             input logic [31:0] data);
    wb_entry_t e;
    e.addr = {addr[31:2], 2'b00};
    e.be   = encode_be(sb, addr[1:0]);
    e.data = sb ? {4{data[7:0]}} : data;
    return e;
  endfunction

endpackage

// File: rtl/write_buffer_fifo.sv
// write_buffer_fifo
// Circular store queue holding encoded write-buffer entries.
// Ports:
//   clock, reset      : clock, asynchronous active-low reset (pointers/count only)
//   push, push_entry  : enqueue request (ignored while full) and its entry
//   pop               : dequeue head (ignored while empty)
//   head_entry        : oldest entry
//   entries           : raw storage view, indexed by slot (for forwarding)
//   head_ptr, count   : oldest slot index and occupancy
//   full, empty       : occupancy flags derived from the registered count
module write_buffer_fifo
  import write_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     pop,
  output wb_entry_t                head_entry,
  output wb_entry_t                entries [DEPTH],
  output logic [$clog2(DEPTH)-1:0] head_ptr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok;
  logic             pop_ok;

  // Flags come from the registered count only, so a push while full is
  // rejected even when a pop happens on the same edge.
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage is deliberately not reset; only pointers/count define validity.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[tail_reg] <= push_entry;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push_ok) begin
        tail_reg <= tail_reg + PTR_W'(1);
      end
      if (pop_ok) begin
        head_reg <= head_reg + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_view
    assign entries[gi] = mem_q[gi];
  end

  assign head_entry = mem_q[head_reg];
  assign head_ptr   = head_reg;
  assign count      = count_reg;

endmodule

// File: rtl/write_buffer.sv
// write_buffer
// Write-through store buffer between the data cache and main memory.
// Stores are queued in write_buffer_fifo and drained one at a time by a
// two-state request/acknowledge FSM (an IDLE cycle separates drains).
// Optional feature macro WRITE_BUFFER_FWD_EN: load forwarding from buffered
// stores; without it, loads are told to wait whenever the buffer is non-empty.
// Ports:
//   clock, reset                       : clock, asynchronous active-low reset
//   wr_valid, wr_sb, wr_addr, wr_data  : store from the cache write-through path
//   full, empty                        : occupancy flags (full stalls upstream)
//   mem_req, mem_addr, mem_data, mem_be: drain request, zero while idle
//   mem_ack                            : memory accepted the current request
//   rd_addr                            : load address for forwarding check
//   rd_hit, rd_conflict, rd_data       : forwarding result
module write_buffer
  import write_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_valid,
  input  logic        wr_sb,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        full,
  output logic        empty,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] rd_addr,
  output logic        rd_hit,
  output logic        rd_conflict,
  output logic [31:0] rd_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  drain_state_t     state_reg;
  drain_state_t     state_next;
  wb_entry_t        push_entry;
  wb_entry_t        head_entry;
  wb_entry_t        fifo_entries [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic             pop;

  assign push_entry = encode_entry(wr_sb, wr_addr, wr_data);

  // Pop only on the accepting edge of a live request; mem_ack in IDLE is
  // ignored by construction.
  assign pop = (state_reg == REQ) && mem_ack;

  write_buffer_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (wr_valid),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .entries    (fifo_entries),
    .head_ptr   (head_ptr),
    .count      (fifo_count),
    .full       (full),
    .empty      (empty)
  );

  // Drain FSM state register. Reset drops any in-flight request at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and drain outputs. The head entry cannot change while in REQ
  // (no pop without ack, and pushes never land on the head slot while the
  // buffer is non-empty), so the request stays stable until accepted.
  always_comb begin
    state_next = state_reg;
    mem_req    = 1'b0;
    mem_addr   = '0;
    mem_data   = '0;
    mem_be     = '0;
    case (state_reg)
      IDLE: begin
        if (!empty) begin
          state_next = REQ;
        end
      end
      REQ: begin
        mem_req  = 1'b1;
        mem_addr = head_entry.addr;
        mem_data = head_entry.data;
        mem_be   = head_entry.be;
        if (mem_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef WRITE_BUFFER_FWD_EN
  // Age-ordered view: slot 0 is the oldest valid entry, higher slots are
  // younger, so the last match in the scan is the youngest.
  wb_entry_t        slot_entry [DEPTH];
  logic [DEPTH-1:0] slot_valid;
  logic             fwd_match;
  wb_entry_t        fwd_entry;
  logic             unused_rd_lane;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    assign slot_entry[gi] = fifo_entries[head_ptr + PTR_W'(gi)];
    assign slot_valid[gi] = (CNT_W'(gi) < fifo_count);
  end

  always_comb begin
    fwd_match = 1'b0;
    fwd_entry = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i] && (slot_entry[i].addr == {rd_addr[31:2], 2'b00})) begin
        fwd_match = 1'b1;
        fwd_entry = slot_entry[i];
      end
    end
  end

  // Only a full-word store can satisfy a load; a byte store forces a wait.
  always_comb begin
    rd_hit      = fwd_match && (fwd_entry.be == 4'b1111);
    rd_conflict = fwd_match && (fwd_entry.be != 4'b1111);
    rd_data     = rd_hit ? fwd_entry.data : '0;
  end

  // Loads compare at word granularity; the lane bits are irrelevant here.
  assign unused_rd_lane = ^rd_addr[1:0];
`else
  // No forwarding: any buffered store may alias the load, so it must wait
  // until the buffer drains.
  logic [DEPTH-1:0] unused_slot;
  logic             unused_misc;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_unused
    assign unused_slot[gi] = ^fifo_entries[gi];
  end

  assign unused_misc = ^{rd_addr, head_ptr, fifo_count};

  always_comb begin
    rd_hit      = 1'b0;
    rd_conflict = !empty;
    rd_data     = '0;
  end
`endif

endmodule

// File: tb/tb_write_buffer.sv
module tb_write_buffer;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_sb = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        full;
  logic        empty;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] rd_addr = '0;
  logic        rd_hit;
  logic        rd_conflict;
  logic [31:0] rd_data;

  int total = 0;
  int bad   = 0;

  write_buffer #(.DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .wr_valid    (wr_valid),
    .wr_sb       (wr_sb),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .full        (full),
    .empty       (empty),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_be      (mem_be),
    .mem_ack     (mem_ack),
    .rd_addr     (rd_addr),
    .rd_hit      (rd_hit),
    .rd_conflict (rd_conflict),
    .rd_data     (rd_data)
  );

  always #5 clock = ~clock;

  // Reference model: a queue of pending stores plus a flag saying a drain
  // request is outstanding.
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;

  ent_t q[$];
  bit   busy = 1'b0;

  function automatic ent_t enc(input bit sb, input logic [31:0] wa, input logic [31:0] wd);
    ent_t e;
    e.a  = wa & ~32'h3;
    e.be = sb ? 4'(1 << wa[1:0]) : 4'hF;
    e.d  = sb ? ({24'h0, wd[7:0]} * 32'h0101_0101) : wd;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] e_addr, e_data, e_rdata;
    logic [3:0]  e_be;
    bit          e_hit, e_conf;
    e_addr = 0; e_data = 0; e_be = 0;
    if (busy && q.size() != 0) begin
      e_addr = q[0].a; e_data = q[0].d; e_be = q[0].be;
    end
`ifdef WRITE_BUFFER_FWD_EN
    begin
      bit m;
      logic [3:0]  mbe;
      logic [31:0] md;
      m = 0; mbe = 0; md = 0;
      foreach (q[i]) begin
        if (q[i].a[31:2] == rd_addr[31:2]) begin
          m = 1; mbe = q[i].be; md = q[i].d;
        end
      end
      e_hit   = m && (mbe == 4'hF);
      e_conf  = m && (mbe != 4'hF);
      e_rdata = e_hit ? md : 32'h0;
    end
`else
    e_hit   = 0;
    e_conf  = (q.size() != 0);
    e_rdata = 0;
`endif
    chk("full",        32'(full),        32'(q.size() == DEPTH));
    chk("empty",       32'(empty),       32'(q.size() == 0));
    chk("mem_req",     32'(mem_req),     32'(busy));
    chk("mem_addr",    mem_addr,         e_addr);
    chk("mem_data",    mem_data,         e_data);
    chk("mem_be",      32'(mem_be),      32'(e_be));
    chk("rd_hit",      32'(rd_hit),      32'(e_hit));
    chk("rd_conflict", 32'(rd_conflict), 32'(e_conf));
    chk("rd_data",     rd_data,          e_rdata);
  endtask

  // One clock: drive inputs at the falling edge, check, then advance the
  // model across the rising edge.
  task automatic cycle(input bit wv, input bit sb, input logic [31:0] wa,
                       input logic [31:0] wd, input bit ack, input logic [31:0] ra);
    bit do_pop, do_push, nb;
    wr_valid = wv; wr_sb = sb; wr_addr = wa; wr_data = wd; mem_ack = ack; rd_addr = ra;
    #1;
    check_all();
    @(posedge clock);
    do_pop  = busy && ack;
    do_push = wv && (q.size() < DEPTH);
    nb      = busy ? !ack : (q.size() != 0);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(enc(sb, wa, wd));
    busy = nb;
    @(negedge clock);
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && (q.size() != 0 || busy); n++) begin
      cycle(0, 0, 0, 0, 1, rd_addr);
    end
    chk("drain_done", 32'(empty), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clock);
    #1;
    check_all();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_empty",   32'(empty),   32'd1);
    @(negedge clock);
    reset = 1'b1;
    cycle(0, 0, 0, 0, 0, 0);

    // Word store drain
    cycle(1, 0, 32'h24, 32'hDEAD_BEEF, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("w_mem_req",  32'(mem_req), 32'd1);
    chk("w_mem_addr", mem_addr,     32'h24);
    chk("w_mem_be",   32'(mem_be),  32'hF);
    chk("w_mem_data", mem_data,     32'hDEAD_BEEF);
    cycle(0, 0, 0, 0, 1, 0);
    chk("w_empty", 32'(empty), 32'd1);
    cycle(0, 0, 0, 0, 0, 0);

    // Byte store drain
    cycle(1, 1, 32'h06, 32'h0000_00AB, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("b_mem_addr", mem_addr,    32'h04);
    chk("b_mem_be",   32'(mem_be), 32'h4);
    chk("b_mem_data", mem_data,    32'hABAB_ABAB);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // Overfill, ordered drain, then refill across the pointer wrap
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 5; i++) begin
        cycle(1, 0, 32'h100 * (r + 1) + 32'(4 * i), 32'h5000 + 32'(16 * r + i), 0, 0);
        if (i == 3) chk("ovf_full", 32'(full), 32'd1);
      end
      for (int k = 0; k < 4; k++) begin
        chk("ovf_order", mem_addr, 32'h100 * (r + 1) + 32'(4 * k));
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0);
      end
      chk("ovf_empty", 32'(empty), 32'd1);
      chk("ovf_noreq", 32'(mem_req), 32'd0);
    end
    // Offset the pointers so the next fill wraps mid-array
    cycle(1, 0, 32'h300, 32'h1, 0, 0);
    drain();
    for (int i = 0; i < 4; i++) cycle(1, 0, 32'h400 + 32'(4 * i), 32'h2 + 32'(i), 0, 0);
    for (int k = 0; k < 4; k++) begin
      chk("wrap_order", mem_addr, 32'h400 + 32'(4 * k));
      cycle(0, 0, 0, 0, 1, 0);
      cycle(0, 0, 0, 0, 0, 0);
    end

`ifdef WRITE_BUFFER_FWD_EN
    cycle(1, 0, 32'h40, 32'h11, 0, 32'h40);
    cycle(1, 0, 32'h40, 32'h22, 0, 32'h40);
    cycle(0, 0, 0, 0, 0, 32'h40);
    chk("fwd_hit",  32'(rd_hit), 32'd1);
    chk("fwd_data", rd_data,     32'h22);
    cycle(1, 1, 32'h41, 32'h33, 0, 32'h40);
    chk("fwd_conf", 32'(rd_conflict), 32'd1);
    chk("fwd_nohit", 32'(rd_hit), 32'd0);
    drain();
`else
    cycle(1, 0, 32'h40, 32'h11, 0, 32'h40);
    chk("nofwd_conf", 32'(rd_conflict), 32'd1);
    chk("nofwd_hit",  32'(rd_hit),      32'd0);
    drain();
    chk("nofwd_conf_empty", 32'(rd_conflict), 32'd0);
`endif

    // Reset in the middle of a drain
    cycle(1, 0, 32'h80, 32'hA, 0, 0);
    cycle(1, 0, 32'h84, 32'hB, 0, 0);
    cycle(1, 0, 32'h88, 32'hC, 0, 0);
    chk("mid_req", 32'(mem_req), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_req",   32'(mem_req), 32'd0);
    chk("mid_rst_empty", 32'(empty),   32'd1);
    q.delete();
    busy = 0;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1, 0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
            32'h40 + 32'($urandom_range(0, 15)), $urandom,
            $urandom_range(0, 2) == 0, 32'h40 + 32'($urandom_range(0, 3) << 2));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/write_buffer.md
WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 SHALL have parameter: DEPTH, 4, number of buffered stores (power of two, 2..16).
REQ-002 SHALL have ports (one clock; reset is asynchronous and active-low):
  clock  in  1  sole clock, all state updates on rising edge
  reset  in  1  asynchronous, active-low reset
  wr_valid  in  1  store from data cache write-through path
  wr_sb  in  1  1 = byte store, 0 = word store
  wr_addr  in  32  store byte address
  wr_data  in  32  store data (byte store uses [7:0])
  full  out  1  buffer holds DEPTH entries; upstream stalls
  empty  out  1  buffer holds zero entries
  mem_req  out  1  drain request to main memory
  mem_addr  out  32  word-aligned drain address
  mem_data  out  32  drain data, byte-lane positioned
  mem_be  out  4  drain byte enables
  mem_ack  in  1  memory accepted current request
  rd_addr  in  32  load address for forwarding check
  rd_hit  out  1  youngest matching entry covers full word
  rd_conflict  out  1  matching entry exists but is partial (byte)
  rd_data  out  32  forwarded word when rd_hit

Function
REQ-003 SHALL store entries FIFO-ordered in a circular array; head/tail pointers wrap modulo DEPTH; a count register of width log2(DEPTH)+1 tracks occupancy.
REQ-004 SHALL accept a push when wr_valid=1 and full=0; wr_valid=1 with full=1 is ignored, with no entry overwritten.
REQ-005 SHALL derive full/empty from registered count only; a push while full is rejected even if a pop occurs in the same cycle.
REQ-006 SHALL handle simultaneous push and pop when not full: both take effect and count remains unchanged.
REQ-007 SHALL encode entries at push: word store -> be=4'b1111, data=wr_data, addr={wr_addr[31:2],2'b00}; byte store -> be=4'b0001<<wr_addr[1:0], data=wr_data[7:0] replicated on all four lanes.
REQ-008 SHALL run drain FSM IDLE->REQ when empty=0; REQ drives mem_req=1 with head entry on mem_addr/mem_data/mem_be; REQ->IDLE on mem_ack=1 with head popped that edge.
REQ-009 SHALL hold mem_req, mem_addr, mem_data and mem_be stable in REQ until mem_ack; a request is never withdrawn.
REQ-010 SHALL give latency: entry pushed at edge N into an empty buffer shows mem_req=1 after edge N+1; back-to-back drains cost 2 cycles per entry (IDLE between).
REQ-011 SHALL ignore mem_ack in IDLE.
REQ-012 SHALL drive mem_addr/mem_data/mem_be to 0 while mem_req=0.

Reset
REQ-013 SHALL asynchronously, on reset=0, clear pointers and count, set FSM to IDLE, mem_req=0, full=0, empty=1, rd_hit=0, rd_conflict=0, rd_data=0.
REQ-014 SHALL discard all pending entries on reset mid-drain; mem_req falls without waiting for mem_ack.
REQ-015 SHALL leave entry storage uninitialised; only pointers/count are reset.

Configuration
REQ-016 SHALL use macro WRITE_BUFFER_FWD_EN: when defined, rd_hit/rd_conflict/rd_data are computed combinationally from rd_addr[31:2] against all valid entries, youngest match wins; be=1111 match -> rd_hit=1 with that data; partial match -> rd_conflict=1, rd_hit=0.
REQ-017 SHALL, without WRITE_BUFFER_FWD_EN, tie rd_hit=0 and rd_data=0, and drive rd_conflict=1 whenever empty=0 so loads wait for drain.

Structure
REQ-018 SHALL place the entry struct (addr, data, be), the FSM state enum (IDLE, REQ) and the byte-enable encode function in shared package write_buffer_pkg.
REQ-019 SHALL keep storage and pointers in one sub-module, write_buffer_fifo; the drain FSM and forwarding logic reside in write_buffer.

Verification
REQ-020 SHALL verify: word push addr 0x24 data 0xDEADBEEF, mem_ack next REQ cycle -> mem_addr=0x24, mem_be=1111, mem_data=0xDEADBEEF, empty=1 after ack.
REQ-021 SHALL verify: byte push addr 0x06 data 0x000000AB -> mem_addr=0x04, mem_be=0100, mem_data=0xABABABAB.
REQ-022 SHALL verify: 5 pushes with mem_ack=0, DEPTH=4 -> full=1 after 4th, 5th dropped, drains emit only first 4 in order, pointers wrap cleanly on 4 further pushes.
REQ-023 SHALL verify: with WRITE_BUFFER_FWD_EN, words 0x11 then 0x22 to addr 0x40, rd_addr=0x40 -> rd_hit=1, rd_data=0x22; byte to 0x41 added -> rd_conflict=1, rd_hit=0.
REQ-024 SHALL verify: reset=0 asserted while mem_req=1 with 3 entries -> mem_req=0 immediately, empty=1, no drain after reset release.
